// File: rtl/bypass_credits_wr_mc.sv
// Per-channel data-beat credit gate for Bypass write requests, merged round-robin onto one registered output.
// Build option: define BYPASS_CREDITS_ROUNDUP_EN to charge a credit for a partial tail beat (ceil instead of floor).
module bypass_credits_wr_mc #(
   parameter int N_CHAN    = 4,
   parameter int DATA_BITS = 512,
   parameter int BLEN_BITS = 7,
   parameter int CRED_BITS = BLEN_BITS + 1,
   parameter int LEN_BITS  = 28,
   parameter int REQ_BITS  = 64,
   parameter int CHAN_BITS = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic [N_CHAN-1:0]          s_req_valid,
   output logic [N_CHAN-1:0]          s_req_ready,
   input  logic [N_CHAN*REQ_BITS-1:0] s_req_data,
   input  logic [N_CHAN-1:0]          xfer,
   output logic                       m_req_valid,
   input  logic                       m_req_ready,
   output logic [REQ_BITS-1:0]        m_req_data,
   output logic [CHAN_BITS-1:0]       m_chan
);

   localparam int BEAT_LOG_BITS = $clog2(DATA_BITS / 8);
   localparam int CMP_BITS      = ((LEN_BITS > CRED_BITS) ? LEN_BITS : CRED_BITS) + 1;
   localparam logic [CRED_BITS-1:0] CRED_MAX = '1;

   logic [CRED_BITS-1:0] cred      [N_CHAN];
   logic [CRED_BITS-1:0] cred_left [N_CHAN];
   logic [CRED_BITS-1:0] cred_next [N_CHAN];
   logic [CMP_BITS-1:0]  n_beats   [N_CHAN];
   logic [N_CHAN-1:0]    elig;
   logic [CHAN_BITS-1:0] rr_ptr;
   logic [CHAN_BITS-1:0] grant_idx;
   logic [CHAN_BITS-1:0] cand;
   logic                 grant_valid;
   logic                 stage_free;
   int                   scan_idx;

   // The comparison runs one bit wider than both operands so neither a long len nor the ceil carry is truncated.
   always_comb begin
      for (int i = 0; i < N_CHAN; i++) begin
`ifdef BYPASS_CREDITS_ROUNDUP_EN
         n_beats[i] = (CMP_BITS'(s_req_data[i*REQ_BITS +: LEN_BITS])
                       + CMP_BITS'((1 << BEAT_LOG_BITS) - 1)) >> BEAT_LOG_BITS;
`else
         n_beats[i] = CMP_BITS'(s_req_data[i*REQ_BITS +: LEN_BITS]) >> BEAT_LOG_BITS;
`endif
         elig[i] = s_req_valid[i] && (CMP_BITS'(cred[i]) >= n_beats[i]);
      end
   end

   assign stage_free = !m_req_valid || m_req_ready;

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      scan_idx    = 0;
      for (int k = 0; k < N_CHAN; k++) begin
         scan_idx = int'(rr_ptr) + k;
         if (scan_idx >= N_CHAN) scan_idx = scan_idx - N_CHAN;
         cand = CHAN_BITS'(scan_idx);
         if (stage_free && !grant_valid && elig[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_comb begin
      s_req_ready = '0;
      if (grant_valid) s_req_ready[grant_idx] = 1'b1;
   end

   // A grant can only consume what eligibility proved is there, so only the increment needs a saturation guard.
   always_comb begin
      for (int i = 0; i < N_CHAN; i++) begin
         cred_left[i] = s_req_ready[i] ? cred[i] - CRED_BITS'(n_beats[i]) : cred[i];
         cred_next[i] = (xfer[i] && (cred_left[i] != CRED_MAX)) ? cred_left[i] + CRED_BITS'(1)
                                                               : cred_left[i];
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < N_CHAN; i++) cred[i] <= '0;
      end else begin
         for (int i = 0; i < N_CHAN; i++) cred[i] <= cred_next[i];
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rr_ptr      <= '0;
         m_req_valid <= 1'b0;
         m_req_data  <= '0;
         m_chan      <= '0;
      end else if (grant_valid) begin
         rr_ptr      <= (grant_idx == CHAN_BITS'(N_CHAN - 1)) ? '0 : grant_idx + CHAN_BITS'(1);
         m_req_valid <= 1'b1;
         m_req_data  <= s_req_data[int'(grant_idx)*REQ_BITS +: REQ_BITS];
         m_chan      <= grant_idx;
      end else if (m_req_ready) begin
         m_req_valid <= 1'b0;
      end
   end

endmodule
